ram_2d_scan_reader: RTL
=======================

// Module: ram_2d_scan_reader
// PURPOSE
//  Read-side controller for the 2D single-port RAM (64x32x8, cs/wr/add_a/add_b/d_in/d_out).
//  On start, drives a read-only scan of a row window in row-major order (add_b fastest).
//  Streams the bytes out over a valid/ready interface with full backpressure.
//  Sits between the RAM and downstream consumers. It is the read counterpart of the RAM writer.
// PARAMETERS
//  ROW_W   6  row address width (add_a); 64 rows
//  COL_W   5  column address width (add_b); 32 columns
//  DATA_W  8  RAM word / stream width
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; ignored unless idle
//  row_first  in   ROW_W   first row of window, sampled on accepted start
//  row_last   in   ROW_W   last row of window (inclusive), sampled on accepted start
//  ram_cs     out  1       RAM chip select
//  ram_wr     out  1       RAM write enable; constant 0
//  ram_add_a  out  ROW_W   RAM row address
//  ram_add_b  out  COL_W   RAM column address
//  ram_d_out  in   DATA_W  RAM read data, valid 1 cycle after address with cs=1
//  m_data     out  DATA_W  stream data
//  m_valid    out  1       stream valid
//  m_ready    in   1       stream ready; a byte transfers when m_valid&&m_ready
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse when the last byte of the window transfers
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, address counters 0, FIFO empty, pending flag 0.
//  FSM IDLE->SCAN on start: latch window. If row_first>row_last, swap the two bounds.
//  Issue counter starts at {row_first,0}.
//  SCAN: issue a read (ram_cs=1, address = counter) when fifo_cnt + rd_pend - pop < 2.
//  Here pop = m_valid&&m_ready.
//  rd_pend is registered and set for 1 cycle after each issue. The returned ram_d_out is pushed into the FIFO.
//  Counter increments col; col 31->0 increments row. Issuing {row_last,31} moves SCAN->DRAIN.
//  DRAIN: no issues. Leave when rd_pend=0, FIFO empty and final pop done.
//  On the cycle the last byte transfers: done=1, busy=0, ->IDLE.
//  Byte count = (row_last-row_first+1)*32. A single-row window gives 32 bytes, the full window 2048.
//  Full throughput: with m_ready held 1, one byte per cycle; first m_valid 2 cycles after start.
//  m_valid and m_data are stable while m_valid&&!m_ready (AXI-style). No byte is lost or duplicated.
//  ram_cs=0 whenever no read is issued. ram_wr is tied 0.
//  start while busy: ignored. start on the same cycle as done: ignored (FSM still leaving DRAIN).
//  Async reset mid-scan: immediate return to reset state. In-flight data is discarded.
// CONFIGURATION
//  SCAN_CHECKSUM_EN defined: add output port chk [DATA_W-1:0].
//  chk is the XOR of all bytes transferred in the current scan. It is cleared on accepted start
//  and holds its value after done until the next start. Reset value is 0.
//  SCAN_CHECKSUM_EN undefined: no chk port and no checksum logic.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE=0, SCAN=1, DRAIN=2); ROWS=64, COLS=32 constants.
//  Sub-module ram_rd_skid_fifo: 2-entry DATA_W FIFO with push/pop/cnt; it gives m_valid/m_data.
//  Top holds the FSM, address counters, rd_pend flag and optional checksum.
// TESTING
//  Preload RAM[r][c]=r^c. start, rows 0..0, m_ready=1 -> 32 bytes 0x00..0x1F, done on the 32nd transfer.
//  Full window 0..63, m_ready=1 -> 2048 bytes in row-major order, 1/cycle, busy for 2050 cycles.
//  Rows 5..6, m_ready toggling randomly -> exactly 64 bytes in order, data stable under stall.
//  m_ready=0 for 20 cycles -> at most 2 reads issued, ram_cs then 0, no data lost on release.
//  row_first=10,row_last=8 -> rows 8..10 (96 bytes). start while busy -> no restart.
//  Assert rst_n=0 mid-scan -> all outputs 0 immediately. A new start rescans from row_first.
//  Checksum check (SCAN_CHECKSUM_EN defined): rows 0..0 with the same data -> chk=0x00 (XOR of 0..31).

Source files
------------

// File: rtl/ram_2d_scan_reader_pkg.sv
// Shared definitions for the 2D RAM scan reader: FSM encoding and RAM geometry.
package ram_2d_scan_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

   localparam int ROWS = 64;
   localparam int COLS = 32;

endpackage

// File: rtl/ram_2d_scan_reader_skid_fifo.sv
// Two-entry skid FIFO that buffers RAM read data and presents it as a valid/data stream.
module ram_rd_skid_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        cnt,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; the output mux hides stale entries while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign valid = (cnt != 2'd0);
   assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ram_2d_scan_reader.sv
// Read-side scan controller for the 2D single-port RAM; streams a row window out over valid/ready.
// Optional XOR checksum output chk is enabled by defining SCAN_CHECKSUM_EN.
module ram_2d_scan_reader
   import ram_2d_scan_reader_pkg::*;
#(
   parameter int ROW_W  = 6,
   parameter int COL_W  = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ROW_W-1:0]  row_first,
   input  logic [ROW_W-1:0]  row_last,
   output logic              ram_cs,
   output logic              ram_wr,
   output logic [ROW_W-1:0]  ram_add_a,
   output logic [COL_W-1:0]  ram_add_b,
   input  logic [DATA_W-1:0] ram_d_out,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
`ifdef SCAN_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] chk
`endif
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   scan_state_t      state_q, state_d;
   logic [ROW_W-1:0] row_q;
   logic [ROW_W-1:0] row_last_q;
   logic [COL_W-1:0] col_q;
   logic             rd_pend_q;
   logic             issue;
   logic             pop;
   logic [1:0]       fifo_cnt;
   logic [2:0]       occ;

   assign pop = m_valid && m_ready;
   // Entries held or in flight after this cycle's pop; keeps the FIFO from overflowing.
   assign occ = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: begin
            issue = (occ < 3'd2);
            if (issue && col_q == COL_LAST && row_q == row_last_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (!rd_pend_q && fifo_cnt == 2'd1 && pop) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q      <= '0;
         row_last_q <= '0;
         col_q      <= '0;
         rd_pend_q  <= 1'b0;
      end else begin
         rd_pend_q <= issue;
         if (state_q == IDLE && start) begin
            row_q      <= (row_first > row_last) ? row_last : row_first;
            row_last_q <= (row_first > row_last) ? row_first : row_last;
            col_q      <= '0;
         end else if (issue) begin
            col_q <= col_q + 1'b1;
            if (col_q == COL_LAST && row_q != row_last_q) row_q <= row_q + 1'b1;
         end
      end
   end

   ram_rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pend_q),
      .push_data (ram_d_out),
      .pop       (pop),
      .cnt       (fifo_cnt),
      .valid     (m_valid),
      .data      (m_data)
   );

   assign ram_cs    = issue;
   assign ram_wr    = 1'b0;
   assign ram_add_a = row_q;
   assign ram_add_b = col_q;
   assign busy      = (state_q != IDLE) && !done;

`ifdef SCAN_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       chk <= '0;
      else if (state_q == IDLE && start) chk <= '0;
      else if (pop)                     chk <= chk ^ m_data;
   end
`endif

endmodule
